// File: rtl/router_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_input_buffer_pkg
// Description : Shared router constants: default flit width and the switch
//               port codes that identify the four router input ports.
// Revision    : 1.0 - initial release
// ============================================================================
package router_input_buffer_pkg;

    // Default flit width used by every router port.
    localparam int FLIT_WIDTH = 32;

    // Switch port codes: one input buffer instance per code.
    localparam logic [1:0] SW_X1    = 2'd0;
    localparam logic [1:0] SW_X2    = 2'd1;
    localparam logic [1:0] SW_Y     = 2'd2;
    localparam logic [1:0] SW_LOCAL = 2'd3;

endpackage : router_input_buffer_pkg
`default_nettype wire

// File: rtl/router_input_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : router_input_buffer_if
// Description : Bundles the upstream link (valid/flit/full) and the
//               flow-control side (empty/en/en_fifo/head register/status) of
//               one router input buffer.
//               slave  = the buffer itself, master = link + flow control.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_input_buffer_if
    import router_input_buffer_pkg::*;
#(
    parameter int FLIT_W = FLIT_WIDTH,
    parameter int DEPTH  = 8
) ();

    localparam int c_CW = $clog2(DEPTH + 1);

    // Upstream link
    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              full;

    // Flow-control side
    logic              empty;
    logic              stage_en;
    logic              rd_en;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;

    // Status
    logic [c_CW-1:0]   count;
    logic              overflow_err;
    logic              underflow_err;

    modport slave (
        input  in_valid, in_flit, stage_en, rd_en,
        output full, empty, out_valid, out_flit, count,
               overflow_err, underflow_err
    );

    modport master (
        output in_valid, in_flit, stage_en, rd_en,
        input  full, empty, out_valid, out_flit, count,
               overflow_err, underflow_err
    );

endinterface : router_input_buffer_if
`default_nettype wire

// File: rtl/router_input_buffer_fifo_mem_2p.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem_2p
// Description : DEPTH x FLIT_W register array with one synchronous write
//               port and one asynchronous read port. Storage is not reset;
//               validity is tracked by the owning FIFO's pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_2p #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              wr_en_i,
    input  wire logic [AW-1:0]     wr_addr_i,
    input  wire logic [FLIT_W-1:0] wr_data_i,
    input  wire logic [AW-1:0]     rd_addr_i,
    output logic      [FLIT_W-1:0] rd_data_o
);

    logic [FLIT_W-1:0] mem_q [DEPTH];

    // Write port: store the incoming flit at the write address.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_mem_2p
`default_nettype wire

// File: rtl/router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : router_input_buffer
// Description : Receive side of the router full/enable handshake. Buffers
//               upstream flits, returns a registered full with FULL_SLACK
//               entries of headroom, and feeds a head-flit register that
//               advances on the flow-control en / en_fifo strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module router_input_buffer
    import router_input_buffer_pkg::*;
#(
    parameter int FLIT_W     = FLIT_WIDTH,
    parameter int DEPTH      = 8,
    parameter int FULL_SLACK = 2
) (
    input wire logic             clk,
    input wire logic             rst_n,
    router_input_buffer_if.slave bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_FULL_LVL  = c_CW'(DEPTH - FULL_SLACK);
    localparam logic [c_AW-1:0] c_LAST_PTR  = c_AW'(DEPTH - 1);

    logic [c_AW-1:0]   wptr_q,  wptr_d;
    logic [c_AW-1:0]   rptr_q,  rptr_d;
    logic [c_CW-1:0]   count_q, count_d;
    logic              empty_q, full_q;
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic              ovf_q, unf_q;

    logic              push, pop, drop, bad_rd;
    logic [FLIT_W-1:0] rd_data;

    fifo_mem_2p #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .AW     (c_AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_addr_i (wptr_q),
        .wr_data_i (bus.in_flit),
        .rd_addr_i (rptr_q),
        .rd_data_o (rd_data)
    );

    // Handshake decode and next-state pointers/count. A pop frees a slot in
    // the same cycle, so a push into a full FIFO still lands when paired with
    // a pop (the read is asynchronous and sees the old entry).
    always_comb begin
        pop     = bus.rd_en && bus.stage_en && !empty_q;
        push    = bus.in_valid && ((count_q < c_DEPTH_CNT) || pop);
        drop    = bus.in_valid && !push;
        bad_rd  = bus.rd_en && (empty_q || !bus.stage_en);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            wptr_d = (wptr_q == c_LAST_PTR) ? '0 : wptr_q + c_AW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == c_LAST_PTR) ? '0 : rptr_q + c_AW'(1);
        end
        count_d = count_q + c_CW'(push) - c_CW'(pop);
    end

    // Pointers, occupancy and flags; flags are derived from next-state count
    // so they line up with the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d >= c_FULL_LVL);
        end
    end

    // Head register: load on pop, bubble on enable without pop, hold when
    // downstream is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else if (bus.stage_en) begin
            out_valid_q <= pop;
            if (pop) begin
                out_flit_q <= rd_data;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (bad_rd) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.count         = count_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_flit      = out_flit_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule : router_input_buffer
`default_nettype wire

// File: tb/tb_router_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_input_buffer
// Description : Self-checking bench for router_input_buffer
//               (FLIT_W=32, DEPTH=8, FULL_SLACK=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_input_buffer;

    localparam int c_FW = 32;
    localparam int c_DEPTH = 8;

    typedef struct {
        logic        iv;
        logic [31:0] flit;
        logic        se;
        logic        re;
        logic [3:0]  cnt;
        logic        emp;
        logic        ful;
        logic        ov;
        logic [31:0] of;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    router_input_buffer_if #(.FLIT_W(c_FW), .DEPTH(c_DEPTH)) bus ();

    router_input_buffer #(
        .FLIT_W     (c_FW),
        .DEPTH      (c_DEPTH),
        .FULL_SLACK (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] f, input logic se, input logic re);
        bus.in_valid = iv;
        bus.in_flit  = f;
        bus.stage_en = se;
        bus.rd_en    = re;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[18];
        logic [31:0] q[$];
        logic [31:0] exp_f;
        logic [31:0] nf;

        n_checks = 0;
        n_errors = 0;

        //            iv    flit     se    re    cnt emp  ful  ov   of       ovf  unf
        vecs[0]  = '{1'b1, 32'h101, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h102, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h103, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h104, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h105, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h106, 1'b0, 1'b0, 6, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'h107, 1'b0, 1'b0, 7, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h108, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h109, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 7, 1'b0, 1'b1, 1'b1, 32'h101, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b1, 32'h102, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 32'h105, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1, 32'h106, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 32'h107, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 1'b0};

        // ---------------- reset state
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_flit", bus.out_flit, 32'h0);
        chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
        chk("rst_unf", 32'(bus.underflow_err), 32'd0);
        rst_n = 1'b1;

        // ---------------- fill / overflow / drain / bubble table
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].flit, vecs[i].se, vecs[i].re);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].ful));
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_out_flit", i), bus.out_flit, vecs[i].of);
            chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow_err), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i), 32'(bus.underflow_err), 32'(vecs[i].unf));
        end

        // ---------------- reset mid-traffic (asynchronous assertion)
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("mid_pre_count", 32'(bus.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_count", 32'(bus.count), 32'd0);
        chk("mid_empty", 32'(bus.empty), 32'd1);
        chk("mid_full", 32'(bus.full), 32'd0);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_out_flit", bus.out_flit, 32'h0);
        chk("mid_ovf", 32'(bus.overflow_err), 32'd0);
        chk("mid_unf", 32'(bus.underflow_err), 32'd0);
        tick();
        rst_n = 1'b1;

        // ---------------- latency: write, then pop, then bubble
        drive(1'b1, 32'hA5, 1'b1, 1'b0);
        tick();
        chk("lat_c1_out_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_c1_empty", 32'(bus.empty), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("lat_c2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_c2_out_flit", bus.out_flit, 32'hA5);
        chk("lat_c2_empty", 32'(bus.empty), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("lat_c3_out_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_c3_out_flit", bus.out_flit, 32'hA5);

        // ---------------- steady state at count=8 across pointer wrap
        for (int i = 0; i < 8; i++) begin
            nf = 32'h200 + 32'(i);
            q.push_back(nf);
            drive(1'b1, nf, 1'b0, 1'b0);
            tick();
        end
        chk("ss_fill_count", 32'(bus.count), 32'd8);
        exp_f = 32'h0;
        for (int k = 0; k < 20; k++) begin
            nf = 32'h300 + 32'(k);
            exp_f = q.pop_front();
            q.push_back(nf);
            drive(1'b1, nf, 1'b1, 1'b1);
            tick();
            chk($sformatf("ss%0d_count", k), 32'(bus.count), 32'd8);
            chk($sformatf("ss%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("ss%0d_out_flit", k), bus.out_flit, exp_f);
        end
        chk("ss_ovf", 32'(bus.overflow_err), 32'd0);
        chk("ss_full", 32'(bus.full), 32'd1);

        // ---------------- stall: head held while stage_en=0
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("stall%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d_out_flit", k), bus.out_flit, exp_f);
        end
        exp_f = q.pop_front();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("stall_release_flit", bus.out_flit, exp_f);
        chk("stall_release_count", 32'(bus.count), 32'd7);
        chk("stall_unf", 32'(bus.underflow_err), 32'd0);

        // ---------------- illegal pop with stage_en=0
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        chk("ill_se_count", 32'(bus.count), 32'd7);
        chk("ill_se_out_valid", 32'(bus.out_valid), 32'd1);
        chk("ill_se_out_flit", bus.out_flit, exp_f);
        chk("ill_se_unf", 32'(bus.underflow_err), 32'd1);
        exp_f = q.pop_front();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("ill_se_next_flit", bus.out_flit, exp_f);
        chk("ill_se_next_count", 32'(bus.count), 32'd6);

        // ---------------- illegal pop while empty
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ill_emp_pre_unf", 32'(bus.underflow_err), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("ill_emp_unf", 32'(bus.underflow_err), 32'd1);
        chk("ill_emp_count", 32'(bus.count), 32'd0);
        chk("ill_emp_empty", 32'(bus.empty), 32'd1);
        chk("ill_emp_out_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("ill_emp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("ill_emp_next_flit", bus.out_flit, 32'h55);
        chk("ill_emp_next_count", 32'(bus.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_router_input_buffer
`default_nettype wire
